mux_4_to_1: RTL and testbench



---
 rtl/mux_4_to_1.sv | 59 +++++
 tb/tb_mux_4_to_1.sv | 113 +++++++++++
 2 files changed

// File: rtl/mux_4_to_1.sv
// 4-to-1 data steer with a combinational output and a one-cycle registered copy.
// Optional registered one-hot select decode on sel_oh when MUX_4_TO_1_SEL_OH_EN is defined.
module mux_4_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_0,
  input  logic [WIDTH-1:0] d_1,
  input  logic [WIDTH-1:0] d_2,
  input  logic [WIDTH-1:0] d_3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y,
`ifdef MUX_4_TO_1_SEL_OH_EN
  output logic [3:0]       sel_oh,
`endif
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] y_d;

  // An unknown select falls to the default arm so X propagates to y.
  always_comb begin
    y = 'x;
    case (s)
      2'b00:   y = d_0;
      2'b01:   y = d_1;
      2'b10:   y = d_2;
      2'b11:   y = d_3;
      default: y = 'x;
    endcase
  end

  always_comb begin
    y_d = y;
    if (rst) y_d = '0;
  end

  always_ff @(posedge clk) begin
    y_q <= y_d;
  end

`ifdef MUX_4_TO_1_SEL_OH_EN
  logic [3:0] sel_oh_d;
  logic [3:0] sel_oh_q;

  always_comb begin
    sel_oh_d = 4'b0001 << s;
    if (rst) sel_oh_d = 4'b0000;
  end

  always_ff @(posedge clk) begin
    sel_oh_q <= sel_oh_d;
  end

  assign sel_oh = sel_oh_q;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Self-checking bench for mux_4_to_1 at WIDTH=1 and WIDTH=8 sharing select and reset.
// Covers sel_oh as well when MUX_4_TO_1_SEL_OH_EN is defined.
module tb_mux_4_to_1;

  logic       clk;
  logic       rst;
  logic [1:0] s;
  logic [7:0] d_0, d_1, d_2, d_3;
  logic [0:0] y1, y1_q;
  logic [7:0] y8, y8_q;
`ifdef MUX_4_TO_1_SEL_OH_EN
  logic [3:0] sel_oh1, sel_oh8;
`endif

  int checks = 0;
  int errors = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_4_to_1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst),
    .d_0(d_0[0:0]), .d_1(d_1[0:0]), .d_2(d_2[0:0]), .d_3(d_3[0:0]),
    .s(s), .y(y1),
`ifdef MUX_4_TO_1_SEL_OH_EN
    .sel_oh(sel_oh1),
`endif
    .y_q(y1_q)
  );

  mux_4_to_1 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst),
    .d_0(d_0), .d_1(d_1), .d_2(d_2), .d_3(d_3),
    .s(s), .y(y8),
`ifdef MUX_4_TO_1_SEL_OH_EN
    .sel_oh(sel_oh8),
`endif
    .y_q(y8_q)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One directed step: drive inputs, check y in the same cycle, then y_q after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] e, input logic [1:0] sv, input logic r);
    logic [7:0] ds [4];
    logic [7:0] exp_y8, exp_q8;
    logic [7:0] exp_y1, exp_q1;
    logic [3:0] exp_oh;
    d_0 = a; d_1 = b; d_2 = c; d_3 = e; s = sv; rst = r;
    ds[0] = a; ds[1] = b; ds[2] = c; ds[3] = e;
    exp_y8 = ds[sv];
    exp_y1 = {7'd0, exp_y8[0]};
    exp_q8 = r ? 8'h00 : exp_y8;
    exp_q1 = r ? 8'h00 : exp_y1;
    exp_oh = r ? 4'b0000 : 4'(1 << int'(sv));
    #1;
    check("y_w8", y8, exp_y8);
    check("y_w1", {7'd0, y1}, exp_y1);
    @(posedge clk);
    #1;
    check("y_q_w8", y8_q, exp_q8);
    check("y_q_w1", {7'd0, y1_q}, exp_q1);
`ifdef MUX_4_TO_1_SEL_OH_EN
    check("sel_oh_w8", {4'd0, sel_oh8}, {4'd0, exp_oh});
    check("sel_oh_w1", {4'd0, sel_oh1}, {4'd0, exp_oh});
`else
    if (exp_oh == 4'b1111) $display("unreachable");
`endif
  endtask

  initial begin
    rst = 1'b1; s = 2'b00;
    d_0 = 8'hA5; d_1 = 8'h3C; d_2 = 8'hFF; d_3 = 8'h00;
    @(posedge clk);
    #1;

    // reset held 3 cycles with s=00: y follows d_0, y_q stays 0
    repeat (3) step(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b1);
    // first edge after release shows selected data
    step(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b0);

    // select sweep (bit 0 gives 1,0,1,0 for the 1-bit instance) and wrap to 00
    for (int i = 0; i < 4; i++) step(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'(i), 1'b0);
    step(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b11, 1'b0);
    step(8'hA5, 8'h3C, 8'hFF, 8'h00, 2'b00, 1'b0);

    // simultaneous select and data change before one edge
    step(8'hA5, 8'h3C, 8'h11, 8'h00, 2'b01, 1'b0);
    step(8'hA5, 8'h3C, 8'h22, 8'h00, 2'b10, 1'b0);

    // mid-operation reset clears regardless of select
    step(8'hA5, 8'h3C, 8'h22, 8'h5A, 2'b11, 1'b1);
    step(8'hA5, 8'h3C, 8'h22, 8'h5A, 2'b11, 1'b0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
